// File: rtl/yuv422_fb_reader.sv
// ---------------------------------------------------------------------------
// yuv422_fb_reader
//
// Read-side scan engine for the YUV422 framebuffer. A frame-start pulse makes
// the block walk the framebuffer BRAM read port from word 0 to word
// N_WORDS-1. It absorbs the BRAM's one-cycle read latency and unpacks every
// 32-bit word into two pixels on a valid/ready stream:
//   word[7:0] = Y0, word[15:8] = U, word[23:16] = Y1, word[31:24] = V
//   even pixel -> (Y0, U), odd pixel -> (Y1, V)
// A two-entry word buffer holds both the words already captured and the one
// read still in flight, so backpressure never loses data and a steady
// ready stream runs at one pixel per clock.
//
// Parameters
//   H_PIXELS  active pixels per line (even)
//   V_LINES   active lines per frame
//   DW        framebuffer word width (32, two pixels per word)
//
// Ports
//   clk_i        clock, shared with the framebuffer BRAM
//   rst_ni       synchronous active-low reset
//   start_i      frame-start pulse, only looked at while idle
//   rd_addr_o    registered BRAM read address
//   rd_d_i       BRAM read data, valid one cycle after the address
//   pix_valid_o  pixel valid
//   pix_ready_i  pixel accepted when high together with valid
//   pix_y_o      luma
//   pix_c_o      chroma (U on even pixels, V on odd pixels)
//   pix_sof_o    first pixel of a frame
//   pix_eol_o    last pixel of a line
//   busy_o       frame scan in progress
//   done_o       one-cycle pulse after the last pixel of a frame is accepted
//
// Build option
//   FB_READER_LOOP_EN  when defined, the engine restarts at word 0 right after
//                      the last pixel, so frames stream continuously after a
//                      single start pulse. Otherwise it returns to idle.
// ---------------------------------------------------------------------------
module yuv422_fb_reader #(
  parameter int H_PIXELS = 640,
  parameter int V_LINES  = 480,
  parameter int DW       = 32,
  localparam int N_WORDS = H_PIXELS * V_LINES / 2,
  localparam int AW      = (N_WORDS > 1) ? $clog2(N_WORDS) : 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  output logic [AW-1:0] rd_addr_o,
  input  logic [DW-1:0] rd_d_i,
  output logic          pix_valid_o,
  input  logic          pix_ready_i,
  output logic [7:0]    pix_y_o,
  output logic [7:0]    pix_c_o,
  output logic          pix_sof_o,
  output logic          pix_eol_o,
  output logic          busy_o,
  output logic          done_o
);

  // Issue counter is one bit wider than the address so it can hold N_WORDS.
  localparam int CW = AW + 1;
  localparam int XW = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;

  localparam logic [CW-1:0] N_WORDS_C = CW'(N_WORDS);
  localparam logic [AW-1:0] LAST_ADDR = AW'(N_WORDS - 1);
  localparam logic [XW-1:0] X_LAST    = XW'(H_PIXELS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [AW-1:0] rd_addr_q;
  logic [CW-1:0] issued_q;
  logic          in_flight_q;

  logic [DW-1:0] buf_q [2];
  logic          wr_ptr_q;
  logic          rd_ptr_q;
  logic [1:0]    occ_q;
  logic          half_q;

  logic [XW-1:0] x_q;
  logic          first_q;
  logic          done_q;

  logic          issue;
  logic          frame_clear;
  logic          handshake;
  logic          push;
  logic          pop;
  logic          last_accept;
  logic [1:0]    occ_sum;
  logic [DW-1:0] head;

  assign handshake = pix_valid_o && pix_ready_i;
  assign push      = in_flight_q;
  assign pop       = handshake && half_q;
  assign occ_sum   = occ_q + {1'b0, in_flight_q};
  assign head      = buf_q[rd_ptr_q];

  // Once every word has been issued, a single buffered word with nothing in
  // flight can only be the last word of the frame, so popping its odd half
  // is the last pixel.
  assign last_accept = (state_q == DRAIN) && pop && (occ_q == 2'd1) && !in_flight_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    issue       = 1'b0;
    frame_clear = 1'b0;
    case (state_q)
      IDLE: begin
        frame_clear = 1'b1;
        if (start_i) begin
          state_d = RUN;
        end
      end
      RUN: begin
        // Only issue when the buffer has room for the word this read returns.
        issue = (occ_sum < 2'd2) && (issued_q < N_WORDS_C);
        if (issued_q == N_WORDS_C) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (last_accept) begin
`ifdef FB_READER_LOOP_EN
          state_d     = RUN;
          frame_clear = 1'b1;
`else
          state_d     = IDLE;
`endif
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The address register already shows the word being read in an issuing
  // cycle; the BRAM latches it at the next edge, and the register then moves
  // on. It stops at the last word instead of wrapping.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_addr_q <= '0;
      issued_q  <= '0;
      x_q       <= '0;
      first_q   <= 1'b1;
    end else if (frame_clear) begin
      rd_addr_q <= '0;
      issued_q  <= '0;
      x_q       <= '0;
      first_q   <= 1'b1;
    end else begin
      if (issue) begin
        issued_q <= issued_q + 1'b1;
        if (rd_addr_q != LAST_ADDR) begin
          rd_addr_q <= rd_addr_q + 1'b1;
        end
      end
      if (handshake) begin
        x_q     <= (x_q == X_LAST) ? '0 : x_q + 1'b1;
        first_q <= 1'b0;
      end
    end
  end

  // Buffer control. Clearing in_flight on reset or idle throws away any read
  // data still coming back from the BRAM.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || (state_q == IDLE)) begin
      in_flight_q <= 1'b0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      occ_q       <= 2'd0;
      half_q      <= 1'b0;
    end else begin
      in_flight_q <= issue;
      if (push) begin
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (handshake) begin
        half_q <= ~half_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  // Word storage needs no reset: outputs are masked while the buffer is empty.
  always_ff @(posedge clk_i) begin
    if (push) begin
      buf_q[wr_ptr_q] <= rd_d_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      done_q <= 1'b0;
    end else begin
      done_q <= last_accept;
    end
  end

  assign rd_addr_o   = rd_addr_q;
  assign pix_valid_o = (occ_q != 2'd0);
  assign pix_y_o     = !pix_valid_o ? 8'h00 : (half_q ? head[23:16] : head[7:0]);
  assign pix_c_o     = !pix_valid_o ? 8'h00 : (half_q ? head[31:24] : head[15:8]);
  assign pix_sof_o   = pix_valid_o && first_q;
  assign pix_eol_o   = pix_valid_o && (x_q == X_LAST);
  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;

endmodule

// File: tb/tb_yuv422_fb_reader.sv
// ---------------------------------------------------------------------------
// tb_yuv422_fb_reader
//
// Directed bench for yuv422_fb_reader with a 4x2 frame (four words). A small
// synchronous BRAM model returns word k = {8'hDk, 8'hCk, 8'hBk, 8'hAk}, so
// pixel order is (Ak,Bk),(Ck,Dk) per word. Inputs change 1 time unit after
// each rising edge and outputs are sampled at the same point.
// ---------------------------------------------------------------------------
module tb_yuv422_fb_reader;

  localparam int H = 4;
  localparam int V = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [1:0] rd_addr;
  logic [31:0] rd_d;
  logic       pix_valid;
  logic       pix_ready;
  logic [7:0] pix_y;
  logic [7:0] pix_c;
  logic       pix_sof;
  logic       pix_eol;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] MEM [4] = '{32'hD0C0B0A0, 32'hD1C1B1A1, 32'hD2C2B2A2, 32'hD3C3B3A3};
  localparam logic [7:0]  EXP_Y [8] = '{8'hA0, 8'hC0, 8'hA1, 8'hC1, 8'hA2, 8'hC2, 8'hA3, 8'hC3};
  localparam logic [7:0]  EXP_C [8] = '{8'hB0, 8'hD0, 8'hB1, 8'hD1, 8'hB2, 8'hD2, 8'hB3, 8'hD3};
  localparam logic        EXP_EOL [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

  yuv422_fb_reader #(
    .H_PIXELS(H),
    .V_LINES (V),
    .DW      (32)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start),
    .rd_addr_o  (rd_addr),
    .rd_d_i     (rd_d),
    .pix_valid_o(pix_valid),
    .pix_ready_i(pix_ready),
    .pix_y_o    (pix_y),
    .pix_c_o    (pix_c),
    .pix_sof_o  (pix_sof),
    .pix_eol_o  (pix_eol),
    .busy_o     (busy),
    .done_o     (done)
  );

  always #5 clk = ~clk;

  // Synchronous-read BRAM: address sampled at the edge, data valid after it.
  always @(posedge clk) begin
    rd_d <= MEM[rd_addr];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, ".rd_addr"}, 32'(rd_addr), 32'd0);
    check_output({tag, ".valid"}, 32'(pix_valid), 32'd0);
    check_output({tag, ".y"}, 32'(pix_y), 32'd0);
    check_output({tag, ".c"}, 32'(pix_c), 32'd0);
    check_output({tag, ".sof"}, 32'(pix_sof), 32'd0);
    check_output({tag, ".eol"}, 32'(pix_eol), 32'd0);
    check_output({tag, ".busy"}, 32'(busy), 32'd0);
    check_output({tag, ".done"}, 32'(done), 32'd0);
  endtask

  // Called just after the edge that samples start high (cycle 0).
  // ready_mode: 0 = always ready, 1 = random 50%, 2 = hold 0 for 20 cycles
  // after the first valid pixel.
  task automatic apply_stimulus(input string tag, input int ready_mode, input int restart_at,
                                input int n_frames, input int exp_last_done,
                                input int exp_first_valid, input logic exp_busy_at_done);
    int  pix = 0;
    int  dones = 0;
    int  last_done = -1;
    int  first_valid = -1;
    int  stall_left = 20;
    bit  seen_valid = 1'b0;
    bit  prev_stall = 1'b0;
    int  k;
    for (int c = 0; c < 400 && dones < n_frames; c++) begin
      start = (c == restart_at);
      if (pix_valid) seen_valid = 1'b1;
      case (ready_mode)
        1: pix_ready = 1'($urandom_range(0, 1));
        2: begin
          if (seen_valid && stall_left > 0) begin
            pix_ready = 1'b0;
            stall_left--;
            if (stall_left == 10) check_output({tag, ".stall_rd_addr"}, 32'(rd_addr), 32'd2);
          end else begin
            pix_ready = 1'b1;
          end
        end
        default: pix_ready = 1'b1;
      endcase
      if (prev_stall) check_output({tag, ".valid_held"}, 32'(pix_valid), 32'd1);
      if (pix_valid) begin
        if (first_valid < 0) first_valid = c;
        k = pix % 8;
        check_output({tag, ".y"}, 32'(pix_y), 32'(EXP_Y[k]));
        check_output({tag, ".c"}, 32'(pix_c), 32'(EXP_C[k]));
        check_output({tag, ".sof"}, 32'(pix_sof), (k == 0) ? 32'd1 : 32'd0);
        check_output({tag, ".eol"}, 32'(pix_eol), 32'(EXP_EOL[k]));
        if (pix_ready) pix++;
      end
      prev_stall = pix_valid && !pix_ready;
      if (done) begin
        dones++;
        last_done = c;
        check_output({tag, ".busy_at_done"}, 32'(busy), 32'(exp_busy_at_done));
      end
      if (dones < n_frames) step();
    end
    start = 1'b0;
    pix_ready = 1'b1;
    check_output({tag, ".pixel_count"}, 32'(pix), 32'(8 * n_frames));
    check_output({tag, ".done_count"}, 32'(dones), 32'(n_frames));
    if (exp_last_done >= 0) check_output({tag, ".done_cycle"}, 32'(last_done), 32'(exp_last_done));
    if (exp_first_valid >= 0) check_output({tag, ".first_valid"}, 32'(first_valid), 32'(exp_first_valid));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    pix_ready = 1'b1;
    step();
    step();
    check_reset_values("reset");
    rst_n = 1'b1;
    step();
    check_output("idle.busy", 32'(busy), 32'd0);

`ifdef FB_READER_LOOP_EN
    $display("[TB] two back-to-back frames from one start");
    pulse_start();
    apply_stimulus("loop", 0, -1, 2, 20, 2, 1'b1);
`else
    $display("[TB] frame with ready held high");
    pulse_start();
    check_output("base.busy_cycle0", 32'(busy), 32'd1);
    check_output("base.valid_cycle0", 32'(pix_valid), 32'd0);
    apply_stimulus("base", 0, -1, 1, 10, 2, 1'b0);
    step();
    check_output("base.done_pulse_end", 32'(done), 32'd0);

    $display("[TB] frame with random ready");
    pulse_start();
    apply_stimulus("rand", 1, -1, 1, -1, 2, 1'b0);
    step();

    $display("[TB] frame with ready held low for 20 cycles");
    pulse_start();
    apply_stimulus("stall", 2, -1, 1, -1, 2, 1'b0);
    step();

    $display("[TB] second start pulse mid-frame");
    pulse_start();
    apply_stimulus("restart", 0, 4, 1, 10, 2, 1'b0);
    for (int i = 0; i < 15; i++) begin
      step();
      check_output("restart.no_extra_done", 32'(done), 32'd0);
      check_output("restart.no_extra_valid", 32'(pix_valid), 32'd0);
    end

    $display("[TB] reset mid-frame");
    pulse_start();
    for (int i = 0; i < 4; i++) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check_reset_values("midreset");
    step();
    pulse_start();
    apply_stimulus("after_reset", 0, -1, 1, 10, 2, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/yuv422_fb_reader.md
# yuv422_fb_reader

Read-side scan engine for the YUV422 framebuffer. On a frame-start pulse it walks the framebuffer BRAM read port from word 0 to the last word, absorbs the BRAM's 1-cycle read latency, and unpacks each 32-bit word into two pixels on a valid/ready stream for the HDMI timing/output stage. A 2-entry word buffer provides full-throughput backpressure without losing in-flight reads.

## Interface
- `H_PIXELS`, default 640: active pixels per line; must be even.
- `V_LINES`, default 480: active lines per frame.
- `DW`, default 32: framebuffer word width; fixed at 32, two pixels per word.
- Derived: `N_WORDS = H_PIXELS*V_LINES/2`; `AW = $clog2(N_WORDS)`.
- `clk_i`  in  1  clock; shared with the framebuffer BRAM.
- `rst_ni`  in  1  reset; synchronous, active-low.
- `start_i`  in  1  frame-start pulse; sampled only in IDLE.
- `rd_addr_o`  out  AW  BRAM read address, registered.
- `rd_d_i`  in  DW  BRAM read data; valid 1 cycle after `rd_addr_o`.
- `pix_valid_o`  out  1  pixel valid.
- `pix_ready_i`  in  1  pixel accepted when high together with valid.
- `pix_y_o`  out  8  luma.
- `pix_c_o`  out  8  chroma: U on even pixels, V on odd pixels.
- `pix_sof_o`  out  1  high with the first pixel of a frame.
- `pix_eol_o`  out  1  high with the last pixel of each line.
- `busy_o`  out  1  high in RUN and DRAIN.
- `done_o`  out  1  one-cycle pulse after the last pixel of a frame is accepted.

## Operation
- Word packing: `[7:0]` = Y0, `[15:8]` = U, `[23:16]` = Y1, `[31:24]` = V.
  - Even pixel outputs (Y0, U).
  - Odd pixel outputs (Y1, V).
- States:
  - IDLE:
    - `start_i` moves to RUN.
    - Clears rd_addr, issue count, buffer, and pixel/line counters.
  - RUN:
    - Issues one read per cycle while `occupancy + in_flight < 2` and `issued < N_WORDS`.
    - An issue drives `rd_addr_o` with the next address and marks in_flight.
    - `rd_d_i` is written into the buffer on the following cycle.
    - Moves to DRAIN when `issued == N_WORDS`.
  - DRAIN:
    - No further reads.
    - Moves to IDLE on acceptance of pixel `2*N_WORDS-1`, pulsing `done_o`.
- Buffer:
  - 2-entry FIFO of words, with a half-select bit: 0 = even pixel, 1 = odd pixel.
  - `pix_valid_o = (occupancy != 0)`.
  - On handshake the half bit toggles. When the odd half is accepted, the head word pops.
  - A push and a pop in the same cycle are both performed; occupancy is unchanged.
- Counters:
  - Pixel-x counter 0..H_PIXELS-1 advances per accepted pixel and wraps.
  - `pix_eol_o = (x == H_PIXELS-1)`.
  - `pix_sof_o` is high only for pixel 0 of the frame.
  - Address arithmetic is AW bits. The last address is `N_WORDS-1`, and the address never wraps within a frame.
- `start_i` during RUN/DRAIN is ignored.
- `pix_valid_o` never drops without acceptance, and outputs are stable while `valid && !ready`.
- Reset mid-frame: next cycle returns to IDLE, buffer empty, and any in-flight read data is discarded.

## Timing
- Reset values:
  - `rd_addr_o = 0`
  - `pix_valid_o = 0`
  - `pix_y_o = 0`
  - `pix_c_o = 0`
  - `pix_sof_o = 0`
  - `pix_eol_o = 0`
  - `busy_o = 0`
  - `done_o = 0`
- Start latency:
  - `start_i` sampled high at edge T.
  - RUN from T, with `rd_addr_o = 0` issued in cycle T+1.
  - Word captured at edge T+2.
  - `pix_valid_o` high in cycle T+2 after the edge, i.e. the first pixel is visible 2 cycles after start.
- Throughput:
  - 1 pixel/cycle with `pix_ready_i` held high; no bubbles after the first pixel.
  - Total frame time with ready high: `2*N_WORDS + 2` cycles from start to `done_o`.
- `busy_o` falls in the same cycle `done_o` is high.
- `rd_addr_o` holds its last value when not issuing.

## Configuration
- `FB_READER_LOOP_EN`:
  - Defined: after the last pixel is accepted, `done_o` pulses and the FSM goes directly to RUN at address 0. Frames stream continuously after a single `start_i`, and `pix_sof_o` marks each frame.
  - Undefined: return to IDLE and wait for `start_i`.

## Test plan
- Frame with H_PIXELS=4, V_LINES=2, BRAM preloaded with word k = {8'hV_k, 8'hY1_k, 8'hU_k, 8'hY0_k} (distinct values), ready always 1:
  - 8 pixels are emitted in order (Y0,U),(Y1,V) per word.
  - `pix_sof_o` is high on pixel 0 only; `pix_eol_o` is high on pixels 3 and 7.
  - `done_o` is high 10 cycles after start.
- Random `pix_ready_i` (50%) over the same frame: the pixel sequence is identical, with no drops or duplicates, and outputs are stable while stalled.
- `pix_ready_i` held 0 for 20 cycles after the first valid: at most 2 reads are issued, and after release all 8 pixels appear correctly.
- `start_i` pulsed again mid-frame: ignored, and exactly one `done_o` is produced.
- `rst_ni` = 0 for 1 cycle mid-frame: all outputs return to their reset values; a following `start_i` produces a full frame beginning at word 0.
- With `FB_READER_LOOP_EN`: a single start gives two back-to-back frames with no gap beyond the 2-cycle refill, and `pix_sof_o` is high at pixel 0 of each.
